// File: rtl/jram_seq_pkg.sv
// Shared constants and the pattern generator for the jcscpu RAM fill-and-verify sequencer.
package jram_seq_pkg;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned CNT_W   = 9;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned TMR_W   = 4;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_W_ADDR = 3'd1;
  localparam logic [STATE_W-1:0] ST_W_SET  = 3'd2;
  localparam logic [STATE_W-1:0] ST_W_GAP  = 3'd3;
  localparam logic [STATE_W-1:0] ST_R_ADDR = 3'd4;
  localparam logic [STATE_W-1:0] ST_R_ENA  = 3'd5;
  localparam logic [STATE_W-1:0] ST_R_GAP  = 3'd6;
  localparam logic [STATE_W-1:0] ST_FINISH = 3'd7;

  localparam logic [1:0] PAT_ADDR    = 2'd0;
  localparam logic [1:0] PAT_INV     = 2'd1;
  localparam logic [1:0] PAT_CHECKER = 2'd2;
  localparam logic [1:0] PAT_ROT     = 2'd3;

  localparam logic [ADDR_W-1:0] FAULT_ADDR = 8'h3C;

  // Data value written to / expected from address a for pattern sel.
  function automatic logic [DATA_W-1:0] pat_value(input logic [1:0] sel,
                                                  input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    case (sel)
      PAT_ADDR:    v = a;
      PAT_INV:     v = ~a;
      PAT_CHECKER: v = a[0] ? 8'hAA : 8'h55;
      default:     v = {a[6:0], a[7]} ^ 8'hA5;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/jram_sequencer_strobe_timer.sv
// Loadable down-counter timing one SA/S/E strobe window; last_c flags its final cycle.
module strobe_timer
  import jram_seq_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             last_c
);

  logic [TMR_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - TMR_W'(1);
    end
  end

  assign last_c = (count == '0);

endmodule

// File: rtl/jram_sequencer.sv
// Fill-and-verify controller for the jcscpu RAM: writes a pattern to all 256 addresses,
// reads them back and reports mismatches. Build option: JRAM_SEQ_FAULT_INJECT_EN.
module jram_sequencer
  import jram_seq_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES = 4,
  parameter int unsigned PAT_W         = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [PAT_W-1:0]  PATTERN,
  input  logic [DATA_W-1:0] RAM_OUT,
  output logic [ADDR_W-1:0] ADDR,
  output logic              SA,
  output logic [DATA_W-1:0] DATA,
  output logic              S,
  output logic              E,
  output logic              BUSY,
  output logic              DONE,
  output logic [CNT_W-1:0]  ERR_CNT,
  output logic              ERR_VALID,
  output logic [ADDR_W-1:0] FIRST_ERR_ADDR
);

  localparam logic [TMR_W-1:0] STROBE_LOAD = TMR_W'(STROBE_CYCLES - 1);

  logic [STATE_W-1:0] state, state_n;
  logic [ADDR_W-1:0]  addr, addr_n;
  logic [PAT_W-1:0]   pat_q, pat_n;
  logic [CNT_W-1:0]   err_cnt, err_cnt_n;
  logic               err_valid, err_valid_n;
  logic [ADDR_W-1:0]  first_err, first_err_n;
  logic [DATA_W-1:0]  expected;
  logic               timer_load, timer_last;

  strobe_timer u_timer (
    .clk      (CLK),
    .reset    (RESET),
    .load     (timer_load),
    .load_val (STROBE_LOAD),
    .last_c   (timer_last)
  );

  // Read-back reference, optionally corrupted at one address to exercise the error path.
`ifdef JRAM_SEQ_FAULT_INJECT_EN
  always_comb begin
    expected = pat_value(2'(pat_q), addr);
    if (addr == FAULT_ADDR) begin
      expected = expected ^ 8'h01;
    end
  end
`else
  always_comb begin
    expected = pat_value(2'(pat_q), addr);
  end
`endif

  always_comb begin
    state_n     = state;
    addr_n      = addr;
    pat_n       = pat_q;
    err_cnt_n   = err_cnt;
    err_valid_n = err_valid;
    first_err_n = first_err;
    timer_load  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (START) begin
          pat_n       = PATTERN;
          err_cnt_n   = '0;
          err_valid_n = 1'b0;
          first_err_n = '0;
          addr_n      = '0;
          state_n     = ST_W_ADDR;
        end
      end
      ST_W_ADDR: if (timer_last) state_n = ST_W_SET;
      ST_W_SET:  if (timer_last) state_n = ST_W_GAP;
      ST_W_GAP: begin
        if (addr == 8'hFF) begin
          addr_n  = '0;
          state_n = ST_R_ADDR;
        end else begin
          addr_n  = addr + ADDR_W'(1);
          state_n = ST_W_ADDR;
        end
      end
      ST_R_ADDR: if (timer_last) state_n = ST_R_ENA;
      ST_R_ENA: begin
        if (timer_last) begin
          if (RAM_OUT != expected) begin
            err_cnt_n = err_cnt + CNT_W'(1);
            if (!err_valid) begin
              err_valid_n = 1'b1;
              first_err_n = addr;
            end
          end
          state_n = ST_R_GAP;
        end
      end
      ST_R_GAP: begin
        // Wrap here so the counter can never start a 257th access.
        if (addr == 8'hFF) begin
          addr_n  = '0;
          state_n = ST_FINISH;
        end else begin
          addr_n  = addr + ADDR_W'(1);
          state_n = ST_R_ADDR;
        end
      end
      ST_FINISH: state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase

    timer_load = (state_n != state) &&
                 ((state_n == ST_W_ADDR) || (state_n == ST_W_SET) ||
                  (state_n == ST_R_ADDR) || (state_n == ST_R_ENA));
  end

  // State, datapath and registered outputs decoded from the next state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ST_IDLE;
      addr      <= '0;
      pat_q     <= '0;
      err_cnt   <= '0;
      err_valid <= 1'b0;
      first_err <= '0;
      SA        <= 1'b0;
      S         <= 1'b0;
      E         <= 1'b0;
      DATA      <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      state     <= state_n;
      addr      <= addr_n;
      pat_q     <= pat_n;
      err_cnt   <= err_cnt_n;
      err_valid <= err_valid_n;
      first_err <= first_err_n;
      SA        <= (state_n == ST_W_ADDR) || (state_n == ST_R_ADDR);
      S         <= (state_n == ST_W_SET);
      E         <= (state_n == ST_R_ENA);
      DATA      <= ((state_n == ST_W_SET) || (state_n == ST_W_GAP)) ?
                   pat_value(2'(pat_n), addr_n) : '0;
      BUSY      <= (state_n != ST_IDLE) && (state_n != ST_FINISH);
      DONE      <= (state_n == ST_FINISH);
    end
  end

  assign ADDR           = addr;
  assign ERR_CNT        = err_cnt;
  assign ERR_VALID      = err_valid;
  assign FIRST_ERR_ADDR = first_err;

endmodule

// File: tb/tb_jram_sequencer.sv
// Directed bench for jram_sequencer with a behavioural jcscpu RAM and a strobe protocol monitor.
module tb_jram_sequencer;

  localparam int N   = 4;
  localparam int LAT = 1 + 512 * (2 * N + 1);
`ifdef JRAM_SEQ_FAULT_INJECT_EN
  localparam int FI = 1;
`else
  localparam int FI = 0;
`endif

  logic       CLK = 1'b0;
  logic       RESET, START;
  logic [1:0] PATTERN;
  logic [7:0] RAM_OUT;
  logic [7:0] ADDR, DATA, FIRST_ERR_ADDR;
  logic       SA, S, E, BUSY, DONE, ERR_VALID;
  logic [8:0] ERR_CNT;

  jram_sequencer #(.STROBE_CYCLES(N), .PAT_W(2)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .PATTERN(PATTERN), .RAM_OUT(RAM_OUT),
    .ADDR(ADDR), .SA(SA), .DATA(DATA), .S(S), .E(E), .BUSY(BUSY), .DONE(DONE),
    .ERR_CNT(ERR_CNT), .ERR_VALID(ERR_VALID), .FIRST_ERR_ADDR(FIRST_ERR_ADDR)
  );

  always #5 CLK = ~CLK;

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Behavioural RAM: SA latches the address register, S writes, E drives the output.
  logic [7:0] mem [256];
  logic [7:0] mar = 8'h00;
  logic       stuck_en = 1'b0, zero_en = 1'b0;
  always @(posedge CLK) begin
    if (SA) mar <= ADDR;
    if (S)  mem[mar] <= DATA;
  end
  always_comb begin
    RAM_OUT = 8'h00;
    if (E) begin
      RAM_OUT = mem[mar];
      if (stuck_en && mar == 8'h21) RAM_OUT[3] = 1'b0;
      if (zero_en) RAM_OUT = 8'h00;
    end
  end

  function automatic logic [7:0] ref_pat(input logic [1:0] p, input logic [7:0] a);
    case (p)
      2'd0:    return a;
      2'd1:    return ~a;
      2'd2:    return (a % 2 == 0) ? 8'h55 : 8'hAA;
      default: return ((a << 1) | (a >> 7)) ^ 8'hA5;
    endcase
  endfunction

  // Protocol monitor on the falling edge.
  logic [1:0] cur_pat = 2'd0;
  int viol = 0, done_count = 0, wr_idx = 0, rd_idx = 0, last_wr = 0, last_rd = 0;
  logic s_d = 1'b0, e_d = 1'b0;
  logic [7:0] data_d = 8'h00;
  always @(negedge CLK) begin
    if (RESET) begin
      wr_idx = 0; rd_idx = 0; s_d = 1'b0; e_d = 1'b0;
    end else begin
      if (int'(SA) + int'(S) + int'(E) > 1) viol++;
      if (S && s_d && DATA !== data_d) viol++;
      if (S && !s_d) begin
        if (ADDR !== 8'(wr_idx) || wr_idx > 255 || rd_idx != 0) viol++;
        if (DATA !== ref_pat(cur_pat, ADDR)) viol++;
        wr_idx++;
      end
      if (E && !e_d) begin
        if (ADDR !== 8'(rd_idx) || wr_idx != 256) viol++;
        rd_idx++;
      end
      if (DONE) begin
        done_count++; last_wr = wr_idx; last_rd = rd_idx; wr_idx = 0; rd_idx = 0;
      end
      s_d = S; e_d = E; data_d = DATA;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int start_cyc = 0;

  task automatic pulse_start(input logic [1:0] p);
    START = 1'b1; PATTERN = p; cur_pat = p; start_cyc = cyc;
    tick(1);
    START = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 0; i < LAT + 200 && !DONE; i++) tick(1);
    if (DONE) lat = cyc - start_cyc;
  endtask

  task automatic finish_run(input string tag, input int cnt, input int valid, input int first);
    int lat;
    wait_done(lat);
    check({tag, "_latency"}, 32'(lat), 32'(LAT));
    check({tag, "_busy_at_done"}, 32'(BUSY), 32'd0);
    check({tag, "_err_cnt"}, 32'(ERR_CNT), 32'(cnt));
    check({tag, "_err_valid"}, 32'(ERR_VALID), 32'(valid));
    check({tag, "_first_err"}, 32'(FIRST_ERR_ADDR), 32'(first));
    tick(1);
    check({tag, "_done_pulse"}, 32'(DONE), 32'd0);
    check({tag, "_writes"}, 32'(last_wr), 32'd256);
    check({tag, "_reads"}, 32'(last_rd), 32'd256);
  endtask

  int dc;
  logic found;

  initial begin
    RESET = 1'b1; START = 1'b0; PATTERN = 2'd0;
    tick(3);
    check("reset_state", {ADDR, SA, DATA, S, E, BUSY, DONE, ERR_CNT, ERR_VALID, FIRST_ERR_ADDR},
          32'd0);
    RESET = 1'b0;
    tick(2);

    // Abort a run in W_SET at address 0x10.
    pulse_start(2'd0);
    check("busy_after_start", 32'(BUSY), 32'd1);
    for (int i = 0; i < 2000 && !(ADDR == 8'h10 && S); i++) tick(1);
    found = (ADDR == 8'h10 && S);
    check("reach_wset_10", 32'(found), 32'd1);
    RESET = 1'b1;
    tick(1);
    check("abort_outputs", {ADDR, SA, DATA, S, E, BUSY, DONE, ERR_CNT, ERR_VALID, FIRST_ERR_ADDR},
          32'd0);
    tick(2);
    RESET = 1'b0;
    dc = done_count;
    tick(20);
    check("abort_no_done", 32'(done_count), 32'(dc));
    check("abort_idle", 32'(BUSY), 32'd0);

    // Pattern 0, healthy RAM.
    pulse_start(2'd0);
    check("p0_busy", 32'(BUSY), 32'd1);
    finish_run("p0", FI, FI, FI ? 32'h3C : 32'h00);
    check("p0_mem_7f", 32'(mem[8'h7F]), 32'h7F);

    // Pattern 2, bit 3 stuck at 0 at 0x21.
    stuck_en = 1'b1;
    pulse_start(2'd2);
    finish_run("p2_stuck", 1 + FI, 1, 32'h21);
    stuck_en = 1'b0;
    check("p2_mem_21", 32'(mem[8'h21]), 32'hAA);

    // Pattern 1, RAM output tied low: only 0xFF (expected 0x00) matches.
    zero_en = 1'b1;
    pulse_start(2'd1);
    finish_run("p1_zero", 255, 1, 32'h00);
    zero_en = 1'b0;
    tick(10);
    check("p1_hold_cnt", 32'(ERR_CNT), 32'd255);

    // Pattern 3 with a second START and PATTERN changes mid-run.
    dc = done_count;
    pulse_start(2'd3);
    check("p3_clear_cnt", 32'(ERR_CNT), 32'd0);
    tick(189);
    START = 1'b1; PATTERN = 2'd0;
    tick(1);
    START = 1'b0; PATTERN = 2'd1;
    finish_run("p3_restart", FI, FI, FI ? 32'h3C : 32'h00);
    tick(20);
    check("p3_single_done", 32'(done_count - dc), 32'd1);
    check("p3_mem_00", 32'(mem[8'h00]), 32'hA5);
    check("protocol", 32'(viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
